// File: rtl/alu_pkg.sv
// Shared types for the ALU command driver: widths, opcode encoding,
// command record and driver FSM states.
package alu_pkg;

   localparam int ALU_W = 8;
   localparam int RES_W = 9;

   typedef enum logic [3:0] {
      ADD      = 4'd0,
      SUB      = 4'd1,
      MUL_RSVD = 4'd2,
      DIV      = 4'd3,
      SHL      = 4'd4,
      SHR      = 4'd5,
      ROL      = 4'd6,
      ROR      = 4'd7,
      AND      = 4'd8,
      OR       = 4'd9,
      XOR      = 4'd10,
      NOR      = 4'd11,
      NAND     = 4'd12,
      XNOR     = 4'd13,
      GT       = 4'd14,
      EQ       = 4'd15
   } alu_op_e;

   // Tag is kept outside the struct because its width is a module parameter.
   typedef struct packed {
      logic [ALU_W-1:0] a;
      logic [ALU_W-1:0] b;
      alu_op_e          sel;
   } alu_cmd_t;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      EXEC = 2'd1,
      RESP = 2'd2
   } drv_state_e;

endpackage

// File: rtl/alu_cmd_fifo.sv
// Parameterised synchronous FIFO with full/empty; DEPTH must be a power of 2.
module alu_cmd_fifo #(
   parameter int DEPTH = 4,
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             push,
   input  logic [WIDTH-1:0] din,
   output logic             full,
   input  logic             pop,
   output logic [WIDTH-1:0] dout,
   output logic             empty
);

   localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CNT_W = $clog2(DEPTH + 1);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic             do_push;
   logic             do_pop;

   assign full    = (count_q == CNT_W'(DEPTH));
   assign empty   = (count_q == '0);
   assign dout    = mem_q[rd_ptr_q];
   assign do_push = push && !full;
   assign do_pop  = pop && !empty;

   // Pointers wrap naturally because DEPTH is a power of 2.
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
      case ({do_push, do_pop})
         2'b10:   count_d = count_q + 1'b1;
         2'b01:   count_d = count_q - 1'b1;
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // Storage carries no reset; only entries below count_q are ever read.
   always_ff @(posedge clk) begin
      if (do_push) mem_q[wr_ptr_q] <= din;
   end

endmodule

// File: rtl/alu_cmd_driver.sv
// Command FIFO + IDLE/EXEC/RESP sequencer driving a combinational ALU.
// Optional divide-by-zero error detection: define ALU_DRV_DIVZERO_EN.
module alu_cmd_driver
   import alu_pkg::*;
#(
   parameter int FIFO_DEPTH = 4,
   parameter int TAG_W      = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             cmd_valid,
   output logic             cmd_ready,
   input  logic [7:0]       cmd_a,
   input  logic [7:0]       cmd_b,
   input  logic [3:0]       cmd_sel,
   input  logic [TAG_W-1:0] cmd_tag,
   output logic [7:0]       alu_a,
   output logic [7:0]       alu_b,
   output logic [3:0]       alu_sel,
   input  logic [8:0]       alu_result,
   output logic             rsp_valid,
   input  logic             rsp_ready,
   output logic [8:0]       rsp_result,
   output logic [TAG_W-1:0] rsp_tag,
   output logic             rsp_zero,
   output logic             rsp_carry,
   output logic             rsp_err,
   output logic             busy
);

   localparam int ENT_W = TAG_W + $bits(alu_cmd_t);

   logic             fifo_full;
   logic             fifo_empty;
   logic             fifo_pop;
   logic [ENT_W-1:0] fifo_din;
   logic [ENT_W-1:0] fifo_dout;
   alu_cmd_t         cmd_in;
   alu_cmd_t         head_cmd;
   logic [TAG_W-1:0] head_tag;

   drv_state_e       state_q, state_d;
   alu_cmd_t         alu_cmd_q, alu_cmd_d;
   logic [TAG_W-1:0] tag_q, tag_d;
   logic             rsp_valid_q, rsp_valid_d;
   logic [RES_W-1:0] rsp_result_q, rsp_result_d;
   logic [TAG_W-1:0] rsp_tag_q, rsp_tag_d;
   logic             rsp_zero_q, rsp_zero_d;
   logic             rsp_carry_q, rsp_carry_d;
   logic             rsp_err_q, rsp_err_d;
   logic             err_now;
   logic [RES_W-1:0] res_now;

   function automatic logic op_err(input alu_cmd_t c);
      logic err;
      err = (c.sel == MUL_RSVD);
`ifdef ALU_DRV_DIVZERO_EN
      err = err || ((c.sel == DIV) && (c.b == '0));
`else
      err = err || 1'b0;
`endif
      return err;
   endfunction

   function automatic logic [RES_W-1:0] gate_result(input logic err,
                                                    input logic [RES_W-1:0] raw);
      return err ? '0 : raw;
   endfunction

   assign cmd_in    = '{a: cmd_a, b: cmd_b, sel: alu_op_e'(cmd_sel)};
   assign fifo_din  = {cmd_tag, cmd_in};
   assign {head_tag, head_cmd} = fifo_dout;

   alu_cmd_fifo #(
      .DEPTH (FIFO_DEPTH),
      .WIDTH (ENT_W)
   ) u_fifo (
      .clk   (clk),
      .rst_n (rst_n),
      .push  (cmd_valid),
      .din   (fifo_din),
      .full  (fifo_full),
      .pop   (fifo_pop),
      .dout  (fifo_dout),
      .empty (fifo_empty)
   );

   always_comb begin
      state_d      = state_q;
      alu_cmd_d    = alu_cmd_q;
      tag_d        = tag_q;
      rsp_valid_d  = rsp_valid_q;
      rsp_result_d = rsp_result_q;
      rsp_tag_d    = rsp_tag_q;
      rsp_zero_d   = rsp_zero_q;
      rsp_carry_d  = rsp_carry_q;
      rsp_err_d    = rsp_err_q;
      fifo_pop     = 1'b0;
      err_now      = op_err(alu_cmd_q);
      res_now      = gate_result(err_now, alu_result);

      case (state_q)
         IDLE: begin
            if (!fifo_empty) begin
               fifo_pop  = 1'b1;
               alu_cmd_d = head_cmd;
               tag_d     = head_tag;
               state_d   = EXEC;
            end
         end
         EXEC: begin
            // Flags derive from the result after the error override.
            rsp_valid_d  = 1'b1;
            rsp_result_d = res_now;
            rsp_tag_d    = tag_q;
            rsp_zero_d   = (res_now[ALU_W-1:0] == '0);
            rsp_carry_d  = res_now[RES_W-1];
            rsp_err_d    = err_now;
            state_d      = RESP;
         end
         RESP: begin
            if (rsp_ready) begin
               rsp_valid_d = 1'b0;
               if (!fifo_empty) begin
                  fifo_pop  = 1'b1;
                  alu_cmd_d = head_cmd;
                  tag_d     = head_tag;
                  state_d   = EXEC;
               end else begin
                  state_d = IDLE;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= IDLE;
         alu_cmd_q    <= '0;
         tag_q        <= '0;
         rsp_valid_q  <= 1'b0;
         rsp_result_q <= '0;
         rsp_tag_q    <= '0;
         rsp_zero_q   <= 1'b0;
         rsp_carry_q  <= 1'b0;
         rsp_err_q    <= 1'b0;
      end else begin
         state_q      <= state_d;
         alu_cmd_q    <= alu_cmd_d;
         tag_q        <= tag_d;
         rsp_valid_q  <= rsp_valid_d;
         rsp_result_q <= rsp_result_d;
         rsp_tag_q    <= rsp_tag_d;
         rsp_zero_q   <= rsp_zero_d;
         rsp_carry_q  <= rsp_carry_d;
         rsp_err_q    <= rsp_err_d;
      end
   end

   assign cmd_ready  = !fifo_full;
   assign busy       = (state_q != IDLE) || !fifo_empty;
   assign alu_a      = alu_cmd_q.a;
   assign alu_b      = alu_cmd_q.b;
   assign alu_sel    = alu_cmd_q.sel;
   assign rsp_valid  = rsp_valid_q;
   assign rsp_result = rsp_result_q;
   assign rsp_tag    = rsp_tag_q;
   assign rsp_zero   = rsp_zero_q;
   assign rsp_carry  = rsp_carry_q;
   assign rsp_err    = rsp_err_q;

endmodule

// File: tb/tb_alu_cmd_driver.sv
// Bench for alu_cmd_driver: behavioural ALU, queue-based response model, directed vectors.
module tb_alu_cmd_driver;

   localparam int DEPTH = 4;
   localparam int TW    = 4;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          cmd_valid;
   logic          cmd_ready;
   logic [7:0]    cmd_a;
   logic [7:0]    cmd_b;
   logic [3:0]    cmd_sel;
   logic [TW-1:0] cmd_tag;
   logic [7:0]    alu_a;
   logic [7:0]    alu_b;
   logic [3:0]    alu_sel;
   logic [8:0]    alu_result;
   logic          rsp_valid;
   logic          rsp_ready;
   logic [8:0]    rsp_result;
   logic [TW-1:0] rsp_tag;
   logic          rsp_zero;
   logic          rsp_carry;
   logic          rsp_err;
   logic          busy;

   always #5 clk = ~clk;

   alu_cmd_driver #(.FIFO_DEPTH(DEPTH), .TAG_W(TW)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .cmd_valid  (cmd_valid),
      .cmd_ready  (cmd_ready),
      .cmd_a      (cmd_a),
      .cmd_b      (cmd_b),
      .cmd_sel    (cmd_sel),
      .cmd_tag    (cmd_tag),
      .alu_a      (alu_a),
      .alu_b      (alu_b),
      .alu_sel    (alu_sel),
      .alu_result (alu_result),
      .rsp_valid  (rsp_valid),
      .rsp_ready  (rsp_ready),
      .rsp_result (rsp_result),
      .rsp_tag    (rsp_tag),
      .rsp_zero   (rsp_zero),
      .rsp_carry  (rsp_carry),
      .rsp_err    (rsp_err),
      .busy       (busy)
   );

   // Behavioural ALU (the environment the driver talks to).
   function automatic logic [8:0] alu_fn(input logic [7:0] a, input logic [7:0] b,
                                         input logic [3:0] s);
      logic [8:0] ea, eb, r;
      ea = {1'b0, a};
      eb = {1'b0, b};
      case (s)
         4'd0:    r = ea + eb;
         4'd1:    r = ea - eb;
         4'd2:    r = ea * eb;
         4'd3:    r = (b == 8'd0) ? 9'h1FF : ea / eb;
         4'd4:    r = {a, 1'b0};
         4'd5:    r = {2'b00, a[7:1]};
         4'd6:    r = {1'b0, a[6:0], a[7]};
         4'd7:    r = {1'b0, a[0], a[7:1]};
         4'd8:    r = ea & eb;
         4'd9:    r = ea | eb;
         4'd10:   r = ea ^ eb;
         4'd11:   r = {1'b0, ~(a | b)};
         4'd12:   r = {1'b0, ~(a & b)};
         4'd13:   r = {1'b0, ~(a ^ b)};
         4'd14:   r = {8'd0, a > b};
         default: r = {8'd0, a == b};
      endcase
      return r;
   endfunction

   assign alu_result = alu_fn(alu_a, alu_b, alu_sel);

   typedef struct {
      logic [8:0]    res;
      logic [TW-1:0] tag;
      logic          z;
      logic          c;
      logic          e;
   } exp_t;

   exp_t exp_q[$];
   int   pass_cnt  = 0;
   int   total_cnt = 0;

   function automatic exp_t model(input logic [7:0] a, input logic [7:0] b,
                                  input logic [3:0] s, input logic [TW-1:0] t);
      exp_t x;
      x.e = (s == 4'd2);
`ifdef ALU_DRV_DIVZERO_EN
      if (s == 4'd3 && b == 8'd0) x.e = 1'b1;
`endif
      x.res = x.e ? 9'd0 : alu_fn(a, b, s);
      x.tag = t;
      x.z   = (x.res[7:0] == 8'd0);
      x.c   = x.res[8];
      return x;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      total_cnt++;
      if (act === req) pass_cnt++;
      else $display("FAIL %s: got %0h, required %0h", name, act, req);
   endtask

   // Per-cycle comparison of every presented response against the ordered model.
   exp_t h;
   always @(negedge clk) begin
      if (rst_n) begin
         if (rsp_valid) begin
            if (exp_q.size() == 0) begin
               chk("stale_rsp", 32'd1, 32'd0);
            end else begin
               h = exp_q[0];
               chk("cmp_result", rsp_result, h.res);
               chk("cmp_tag", rsp_tag, h.tag);
               chk("cmp_zero", rsp_zero, h.z);
               chk("cmp_carry", rsp_carry, h.c);
               chk("cmp_err", rsp_err, h.e);
               if (rsp_ready) void'(exp_q.pop_front());
            end
         end
         if (cmd_valid && cmd_ready) exp_q.push_back(model(cmd_a, cmd_b, cmd_sel, cmd_tag));
      end
   end

   always @(negedge rst_n) exp_q.delete();

   task automatic send(input logic [7:0] a, input logic [7:0] b, input logic [3:0] s,
                       input logic [TW-1:0] t);
      bit ok;
      ok = 0;
      @(posedge clk); #1;
      cmd_valid = 1'b1; cmd_a = a; cmd_b = b; cmd_sel = s; cmd_tag = t;
      for (int n = 0; n < 20; n++) begin
         @(negedge clk);
         if (cmd_ready) begin ok = 1; break; end
      end
      if (!ok) chk("send_timeout", 32'd0, 32'd1);
      @(posedge clk); #1;
      cmd_valid = 1'b0;
   endtask

   task automatic wait_rsp(output bit ok, output int cyc);
      ok = 0; cyc = -1;
      for (int n = 0; n < 20; n++) begin
         @(negedge clk);
         if (rsp_valid) begin ok = 1; cyc = n; break; end
      end
   endtask

   task automatic run_one(input string name, input logic [7:0] a, input logic [7:0] b,
                          input logic [3:0] s, input logic [TW-1:0] t,
                          input logic [8:0] er, input logic ez, input logic ec,
                          input logic ee, input bit chk_lat);
      bit ok;
      int cyc;
      rsp_ready = 1'b0;
      send(a, b, s, t);
      wait_rsp(ok, cyc);
      chk({name, "_valid"}, ok, 1);
      if (chk_lat) begin
         chk({name, "_latency"}, cyc, 2);
         chk({name, "_alu_a"}, alu_a, a);
         chk({name, "_alu_b"}, alu_b, b);
         chk({name, "_alu_sel"}, alu_sel, s);
      end
      chk({name, "_result"}, rsp_result, er);
      chk({name, "_zero"}, rsp_zero, ez);
      chk({name, "_carry"}, rsp_carry, ec);
      chk({name, "_err"}, rsp_err, ee);
      chk({name, "_tag"}, rsp_tag, t);
      @(posedge clk); #1 rsp_ready = 1'b1;
      @(posedge clk); #1 rsp_ready = 1'b0;
   endtask

   task automatic offer_burst(input int n_cmd, input int cycles, output int acc);
      acc = 0;
      for (int cyc = 0; cyc < cycles; cyc++) begin
         @(posedge clk); #1;
         if (acc < n_cmd) begin
            cmd_valid = 1'b1;
            cmd_a     = 8'(10 * acc + 1);
            cmd_b     = 8'(acc);
            cmd_sel   = 4'd0;
            cmd_tag   = TW'(acc);
         end else begin
            cmd_valid = 1'b0;
         end
         @(negedge clk);
         if (cmd_valid && cmd_ready) acc++;
      end
      @(posedge clk); #1 cmd_valid = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout, required completion");
      $fatal(1, "watchdog");
   end

   initial begin
      int         acc;
      int         got;
      int         stale;
      int         last_cyc;
      bit         ok;
      int         cyc;
      logic [8:0] held;
      logic [TW-1:0] tags [8];
      int         when [8];

      rst_n = 1'b0; cmd_valid = 1'b0; cmd_a = '0; cmd_b = '0; cmd_sel = '0;
      cmd_tag = '0; rsp_ready = 1'b0;
      repeat (3) @(negedge clk);
      chk("rst_cmd_ready", cmd_ready, 1);
      chk("rst_busy", busy, 0);
      chk("rst_rsp_valid", rsp_valid, 0);
      chk("rst_alu_a", alu_a, 0);
      chk("rst_alu_b", alu_b, 0);
      chk("rst_alu_sel", alu_sel, 0);
      chk("rst_rsp_result", rsp_result, 0);
      chk("rst_rsp_tag", rsp_tag, 0);
      rst_n = 1'b1;

      run_one("add", 8'd200, 8'd100, 4'd0, 4'd1, 9'h12C, 1'b0, 1'b1, 1'b0, 1'b1);
      run_one("sub", 8'd5, 8'd7, 4'd1, 4'd2, 9'h1FE, 1'b0, 1'b1, 1'b0, 1'b0);
      run_one("eq", 8'h3C, 8'h3C, 4'd15, 4'd3, 9'h001, 1'b0, 1'b0, 1'b0, 1'b0);
      run_one("mul", 8'd3, 8'd4, 4'd2, 4'd4, 9'h000, 1'b1, 1'b0, 1'b1, 1'b0);
      run_one("xor", 8'hFF, 8'hFF, 4'd10, 4'd5, 9'h000, 1'b1, 1'b0, 1'b0, 1'b0);
      run_one("div", 8'd7, 8'd2, 4'd3, 4'd6, 9'h003, 1'b0, 1'b0, 1'b0, 1'b0);
`ifdef ALU_DRV_DIVZERO_EN
      run_one("div0", 8'd7, 8'd0, 4'd3, 4'd7, 9'h000, 1'b1, 1'b0, 1'b1, 1'b0);
`else
      run_one("div0", 8'd7, 8'd0, 4'd3, 4'd7, 9'h1FF, 1'b0, 1'b1, 1'b0, 1'b0);
`endif
      @(negedge clk);
      chk("idle_busy", busy, 0);

      // Backpressure: one command in RESP plus a full FIFO.
      rsp_ready = 1'b0;
      offer_burst(6, 12, acc);
      @(negedge clk);
      chk("bp_accepted", acc, DEPTH + 1);
      chk("bp_cmd_ready", cmd_ready, 0);
      chk("bp_rsp_valid", rsp_valid, 1);
      chk("bp_rsp_tag", rsp_tag, 0);
      held = rsp_result;
      repeat (3) @(negedge clk);
      chk("bp_hold_result", rsp_result, held);
      chk("bp_hold_valid", rsp_valid, 1);
      @(posedge clk); #1 rsp_ready = 1'b1;
      got = 0;
      for (int n = 0; n < 30; n++) begin
         @(negedge clk);
         if (rsp_valid && got < 8) begin tags[got] = rsp_tag; when[got] = n; got++; end
      end
      chk("bp_rsp_count", got, DEPTH + 1);
      last_cyc = when[0];
      for (int k = 0; k < 5; k++) begin
         chk("bp_rsp_order", tags[k], k);
         if (k > 0) chk("bp_rsp_spacing", when[k] - last_cyc, 2);
         last_cyc = when[k];
      end
      chk("bp_drained_ready", cmd_ready, 1);
      chk("bp_drained_busy", busy, 0);

      // Reset while in EXEC with three commands still queued.
      rsp_ready = 1'b0;
      offer_burst(5, 10, acc);
      chk("rst_mid_accepted", acc, 5);
      wait_rsp(ok, cyc);
      chk("rst_mid_first_rsp", ok, 1);
      @(posedge clk); #1 rsp_ready = 1'b1;
      @(posedge clk); #1 rsp_ready = 1'b0;
      @(negedge clk);
      chk("rst_mid_exec_busy", busy, 1);
      chk("rst_mid_exec_valid", rsp_valid, 0);
      #1 rst_n = 1'b0;
      #1;
      chk("rst_mid_rsp_valid", rsp_valid, 0);
      chk("rst_mid_cmd_ready", cmd_ready, 1);
      chk("rst_mid_busy", busy, 0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      rsp_ready = 1'b1;
      stale = 0;
      for (int n = 0; n < 10; n++) begin
         @(negedge clk);
         if (rsp_valid) stale++;
      end
      chk("rst_mid_no_stale", stale, 0);
      chk("rst_mid_after_busy", busy, 0);
      chk("model_drained", exp_q.size(), 0);

      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule

// File: doc/alu_cmd_driver.md
Name: alu_cmd_driver

Overview:
Initiator-side sequencer for the 8-bit combinational ALU. It accepts tagged operation commands over a valid/ready interface and buffers them in a small FIFO. It drives the ALU operand and select inputs from registers, captures the 9-bit ALU result, and returns it with flags over a valid/ready response interface. It sits between the instruction/control logic and the ALU datapath.

Parameters:
FIFO_DEPTH, 4, command FIFO entries; power of 2, minimum 2.
TAG_W, 4, width of the opaque command tag returned with each response.

Ports:
clk  in  1  single clock, rising edge.
rst_n  in  1  reset, asynchronous, active-low.
cmd_valid  in  1  command offered.
cmd_ready  out  1  command FIFO not full.
cmd_a  in  8  operand A.
cmd_b  in  8  operand B.
cmd_sel  in  4  ALU operation select; same encoding as the ALU.
cmd_tag  in  TAG_W  tag returned unchanged with the response.
alu_a  out  8  registered operand A to the ALU.
alu_b  out  8  registered operand B to the ALU.
alu_sel  out  4  registered select to the ALU.
alu_result  in  9  combinational ALU result.
rsp_valid  out  1  response available.
rsp_ready  in  1  response consumer ready.
rsp_result  out  9  captured result.
rsp_tag  out  TAG_W  tag of the completed command.
rsp_zero  out  1  rsp_result[7:0] == 0.
rsp_carry  out  1  rsp_result[8].
rsp_err  out  1  unsupported operation (or divide by zero when the optional feature is built in).
busy  out  1  FSM not IDLE or FIFO not empty.

Behaviour:
- Reset (async assert, sync deassert by the upstream reset logic):
  - FIFO is empty and pointers/count are 0; FSM goes to IDLE.
  - All registered outputs are 0: alu_a, alu_b, alu_sel, rsp_*, rsp_valid.
  - cmd_ready=1 and busy=0.
- Reset mid-operation flushes the FIFO and any in-flight command. rsp_valid drops immediately; no partial response is ever presented.
- Command accept: cmd_valid && cmd_ready at a rising edge writes {a,b,sel,tag} to the FIFO.
- cmd_ready = !full, with no combinational dependence on pop. When full, a same-cycle pop does not raise cmd_ready.
- FIFO pointers wrap modulo FIFO_DEPTH; count ranges 0..FIFO_DEPTH.
- FSM states are IDLE, EXEC, RESP.
- IDLE: if the FIFO is not empty, pop the head and load alu_a/alu_b/alu_sel plus an internal tag register, then go to EXEC. Otherwise stay in IDLE.
- EXEC: alu_* are stable for the full cycle. At the end of the cycle, capture rsp_result=alu_result, rsp_tag, rsp_zero, rsp_carry and rsp_err; set rsp_valid=1; go to RESP.
- RESP: rsp_* hold stable while rsp_valid && !rsp_ready. On the handshake:
  - if the FIFO is not empty, pop the next command into alu_* and go to EXEC (back-to-back, so rsp_valid is low for exactly one cycle);
  - else clear rsp_valid and go to IDLE.
- alu_* hold their last value in IDLE and RESP.
- Latency: a command accepted into an empty, idle block at edge k is popped at edge k+1, and rsp_valid is high after edge k+2. Sustained throughput is one operation per 2 cycles.
- Unsupported select 4'b0010 (multiply is not implemented): rsp_err=1, rsp_result=0, rsp_zero=1, rsp_carry=0.
- Flags are computed from the final rsp_result after any error override.
- Responses are returned strictly in command order.

Optional Feature:
ALU_DRV_DIVZERO_EN
- Defined: a command with sel 4'b0011 and b==0 gives rsp_err=1, rsp_result=0, rsp_zero=1, rsp_carry=0. alu_result is ignored for that command.
- Undefined: no divide-by-zero check; the raw alu_result passes through and rsp_err reflects only the unsupported-select case.

Decomposition:
- Package alu_pkg holds:
  - ALU_W=8 and RES_W=9;
  - the opcode enum alu_op_e (ADD, SUB, MUL_RSVD, DIV, SHL, SHR, ROL, ROR, AND, OR, XOR, NOR, NAND, XNOR, GT, EQ);
  - the command struct alu_cmd_t {a,b,sel}, with tag carried separately because it is parameterised;
  - the FSM state enum drv_state_e.
- One sub-module, alu_cmd_fifo: a parameterised synchronous FIFO with full/empty, using the same clk and rst_n.

Test Plan:
- ADD a=200, b=100 -> rsp_result=9'h12C, carry=1, zero=0, err=0, rsp_valid after edge k+2.
- SUB a=5, b=7 -> rsp_result=9'h1FE, carry=1; EQ a=b=8'h3C -> rsp_result=1, zero=0.
- sel=4'b0010 a=3, b=4 -> err=1, result=0, zero=1.
- With ALU_DRV_DIVZERO_EN, DIV a=7, b=0 -> err=1, result=0; without it, err=0 and result equals alu_result.
- Backpressure: rsp_ready=0 with 6 commands offered -> exactly FIFO_DEPTH+1=5 accepted, then cmd_ready=0. rsp_* stay stable. Release rsp_ready -> 5 responses come back in order with tags 0..4, one every 2 cycles.
- Assert rst_n=0 while in EXEC with 3 commands queued -> rsp_valid=0 and cmd_ready=1 immediately; after release, busy=0 and no stale response appears.
